ex_muldiv: RTL and testbench

// - EX-stage multi-cycle multiply/divide unit with architectural HI/LO registers; consumes EX_* operands/op from the ID/EX register.
// - Runs MULT/MULTU/DIV/DIVU in the background so younger non-HI/LO instructions keep flowing.
// - Raises MD_Stall, fed into the ID/EX Stall input, when an HI/LO consumer or a new mul/div op meets a busy unit.

---
 rtl/ex_muldiv_pkg.sv | 44 ++++
 rtl/ex_muldiv_if.sv | 40 ++++
 rtl/ex_muldiv_div_iter.sv | 75 +++++++
 rtl/ex_muldiv.sv | 167 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Package  : muldiv_pkg
// Purpose  : Shared definitions for the EX-stage multiply/divide unit:
//            HI/LO op encoding, divide latency, counter width, FSM states
//            and op-class helper functions.
// Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

  typedef logic [3:0] md_op_t;

  localparam md_op_t MD_NOP   = 4'd0;
  localparam md_op_t MD_MULT  = 4'd1;
  localparam md_op_t MD_MULTU = 4'd2;
  localparam md_op_t MD_DIV   = 4'd3;
  localparam md_op_t MD_DIVU  = 4'd4;
  localparam md_op_t MD_MTHI  = 4'd5;
  localparam md_op_t MD_MTLO  = 4'd6;
  localparam md_op_t MD_MFHI  = 4'd7;
  localparam md_op_t MD_MFLO  = 4'd8;

  // 1 setup + 32 restoring iterations + 1 sign fix-up
  localparam int DIV_CYCLES = 34;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  // Any op that touches HI/LO (codes 9..15 behave as NOP)
  function automatic logic is_hilo_op(md_op_t op);
    return (op >= MD_MULT) && (op <= MD_MFLO);
  endfunction

  // Ops that are consumed by the unit itself (not the MF* reads)
  function automatic logic is_issue_op(md_op_t op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
// Interface : ex_muldiv_if
// Purpose   : EX-stage <-> multiply/divide unit signal bundle.
//   EX_MD_Op      op code from EX decode
//   EX_Hold       EX held by another stall source
//   EX_Operand_A  rs value (dividend / multiplicand / MTHI-MTLO source)
//   EX_Operand_B  rt value (divisor / multiplier)
//   MD_Stall      hold ID/EX and upstream this cycle
//   MD_Busy       multiply or divide in progress
//   MD_Result     HI for MFHI, LO for MFLO, else 0
//   HI, LO        architectural HI/LO registers
// Modports: master = EX stage side, slave = the unit.
// Revision  : 1.0  initial release
// ============================================================================
interface ex_muldiv_if;
  import muldiv_pkg::*;

  md_op_t      EX_MD_Op;
  logic        EX_Hold;
  logic [31:0] EX_Operand_A;
  logic [31:0] EX_Operand_B;
  logic        MD_Stall;
  logic        MD_Busy;
  logic [31:0] MD_Result;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output EX_MD_Op, EX_Hold, EX_Operand_A, EX_Operand_B,
    input  MD_Stall, MD_Busy, MD_Result, HI, LO
  );

  modport slave (
    input  EX_MD_Op, EX_Hold, EX_Operand_A, EX_Operand_B,
    output MD_Stall, MD_Busy, MD_Result, HI, LO
  );

endinterface
`default_nettype wire

// File: rtl/ex_muldiv_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_div_iter
// Purpose  : 32-step unsigned restoring divider core, one quotient bit per
//            clock. A start pulse loads the operands; done rises after the
//            32nd iteration and holds until the next start.
//   clk, reset    clock, synchronous active-high reset
//   start_i       load dividend/divisor and begin
//   dividend_i    dividend magnitude
//   divisor_i     divisor magnitude (0 yields all-ones quotient, rem=dividend)
//   done_o        quotient/remainder valid
//   quotient_o    unsigned quotient
//   remainder_o   unsigned remainder
// Revision : 1.0  initial release
// ============================================================================
module muldiv_div_iter (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        start_i,
  input  wire logic [31:0] dividend_i,
  input  wire logic [31:0] divisor_i,
  output logic             done_o,
  output logic [31:0]      quotient_o,
  output logic [31:0]      remainder_o
);

  logic [31:0] rem_q, quo_q, dvs_q;
  logic [4:0]  step_q;
  logic        run_q, done_q;

  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nxt, w_quo_nxt;

  // Shift the next dividend bit into the partial remainder and trial-subtract;
  // the remainder is restored (kept un-subtracted) when the trial goes negative.
  assign w_shift   = {rem_q, quo_q[31]};
  assign w_diff    = w_shift - {1'b0, dvs_q};
  assign w_ge      = ~w_diff[32];
  assign w_rem_nxt = w_ge ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_nxt = {quo_q[30:0], w_ge};

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      step_q <= '0;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      rem_q  <= w_rem_nxt;
      quo_q  <= w_quo_nxt;
      step_q <= step_q + 5'd1;
      if (step_q == 5'd31) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Purpose  : EX-stage multi-cycle multiply/divide unit owning HI/LO.
//            MULT/MULTU/DIV/DIVU run in the background; HI/LO consumers or a
//            new mul/div op arriving while busy raise MD_Stall.
//   clk, reset   clock, synchronous active-high reset
//   md (slave)   EX op/operands in; stall, busy, MF* result, HI/LO out
// Parameters:
//   MUL_CYCLES   busy cycles for MULT/MULTU (2..8)
// Revision : 1.0  initial release
// ============================================================================
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  wire logic  clk,
  input  wire logic  reset,
  ex_muldiv_if.slave md
);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;

  md_op_t      w_op;
  logic        w_busy, w_accept;
  logic [63:0] w_prod;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic        w_div_start, w_div_done;
  logic [31:0] w_quo, w_rem, w_quo_fix, w_rem_fix;

  assign w_op     = md.EX_MD_Op;
  assign w_busy   = (state_q != IDLE);
  assign w_accept = !md.EX_Hold && !w_busy && is_issue_op(w_op);

  // Product is formed from latched operands and only committed at the end of
  // the busy window, leaving the whole window available for retiming.
  assign w_prod = sgn_q ? ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q})
                        : ({32'd0, a_q} * {32'd0, b_q});

  // Signed divide works on magnitudes; 0x8000_0000 negates to itself, which
  // is the correct unsigned magnitude.
  assign w_a_neg = sgn_q & a_q[31];
  assign w_b_neg = sgn_q & b_q[31];
  assign w_a_mag = w_a_neg ? (32'd0 - a_q) : a_q;
  assign w_b_mag = w_b_neg ? (32'd0 - b_q) : b_q;

  // First busy cycle is the setup cycle: it kicks off the iterative core.
  assign w_div_start = (state_q == DIV) && (cnt_q == '0);

  muldiv_div_iter u_div_iter (
    .clk         (clk),
    .reset       (reset),
    .start_i     (w_div_start),
    .dividend_i  (w_a_mag),
    .divisor_i   (w_b_mag),
    .done_o      (w_div_done),
    .quotient_o  (w_quo),
    .remainder_o (w_rem)
  );

  // Truncation toward zero: quotient sign = sign(A)^sign(B), remainder
  // follows A.
  assign w_quo_fix = (w_a_neg ^ w_b_neg) ? (32'd0 - w_quo) : w_quo;
  assign w_rem_fix = w_a_neg ? (32'd0 - w_rem) : w_rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          unique case (w_op)
            MD_MULT, MD_MULTU: begin
              state_d = MUL;
              cnt_d   = '0;
              a_d     = md.EX_Operand_A;
              b_d     = md.EX_Operand_B;
              sgn_d   = (w_op == MD_MULT);
            end
            MD_DIV, MD_DIVU: begin
              state_d = DIV;
              cnt_d   = '0;
              a_d     = md.EX_Operand_A;
              b_d     = md.EX_Operand_B;
              sgn_d   = (w_op == MD_DIV);
            end
            MD_MTHI: hi_d = md.EX_Operand_A;
            MD_MTLO: lo_d = md.EX_Operand_A;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cnt_q == MUL_LAST) begin
          state_d      = IDLE;
          cnt_d        = '0;
          {hi_d, lo_d} = w_prod;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIV: begin
        if ((cnt_q == DIV_LAST) && w_div_done) begin
          state_d = IDLE;
          cnt_d   = '0;
          // Divide by zero leaves the dividend untouched in HI.
          if (b_q == 32'd0) begin
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = w_rem_fix;
            lo_d = w_quo_fix;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
    end
  end

  assign md.MD_Busy   = w_busy;
  assign md.MD_Stall  = w_busy && is_hilo_op(w_op);
  assign md.MD_Result = (w_op == MD_MFHI) ? hi_q :
                        (w_op == MD_MFLO) ? lo_q : 32'd0;
  assign md.HI        = hi_q;
  assign md.LO        = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Purpose  : Self-checking bench for ex_muldiv with a plain-arithmetic
//            HI/LO reference model and randomized operations.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_muldiv;
  import muldiv_pkg::*;

  localparam int MULN = 4;
  localparam int DIVN = 34;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  logic [31:0] m_hi, m_lo;

  ex_muldiv_if mdif ();

  ex_muldiv #(.MUL_CYCLES(MULN)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural HI/LO effect of one op.
  task automatic model(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT:  begin sp = sa * sb; {m_hi, m_lo} = sp; end
      MD_MULTU: begin up = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = up; end
      MD_DIVU: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      MD_DIV: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Present an op for one edge (accepted there when idle), then NOP with
  // scrambled operands so that late operand changes would be noticed.
  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    mdif.EX_MD_Op     = op;
    mdif.EX_Operand_A = a;
    mdif.EX_Operand_B = b;
    mdif.EX_Hold      = 1'b0;
    step();
    mdif.EX_MD_Op     = MD_NOP;
    mdif.EX_Operand_A = $urandom;
    mdif.EX_Operand_B = $urandom;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (mdif.MD_Busy && cyc < 200) begin
      cyc++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mdif.EX_MD_Op = MD_MFHI;
    repeat (3) step();
    n_tests++; if (mdif.HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", mdif.HI); end
    n_tests++; if (mdif.LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", mdif.LO); end
    n_tests++; if (mdif.MD_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", mdif.MD_Busy); end
    n_tests++; if (mdif.MD_Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", mdif.MD_Stall); end
    reset = 1'b0;
    mdif.EX_MD_Op = MD_NOP;
    m_hi = 0; m_lo = 0;
    step();
  endtask

  task automatic test_mult_stall();
    int cnt;
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    model(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    step();                       // one unrelated instruction, then MFLO
    mdif.EX_MD_Op = MD_MFLO;
    #1;
    cnt = 0;
    while (mdif.MD_Stall && cnt < 100) begin cnt++; step(); end
    n_tests++; if (cnt !== MULN - 1) begin n_fail++; $display("FAIL mult_stall_cycles: got %0d want %0d", cnt, MULN - 1); end
    n_tests++; if (mdif.HI !== 32'hFFFF_FFFF || mdif.HI !== m_hi) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", mdif.HI); end
    n_tests++; if (mdif.LO !== 32'hFFFF_FFFA || mdif.LO !== m_lo) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffa", mdif.LO); end
    n_tests++; if (mdif.MD_Result !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mflo_result: got %h want fffffffa", mdif.MD_Result); end
    mdif.EX_MD_Op = MD_NOP;
    step();
  endtask

  task automatic test_div_cases();
    md_op_t      ops [4] = '{MD_DIV, MD_DIVU, MD_DIVU, MD_DIV};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'd7, 32'h1234, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] ehi [4] = '{32'hFFFF_FFFF, 32'd1, 32'h1234, 32'd0};
    logic [31:0] elo [4] = '{32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      model(ops[i], as[i], bs[i]);
      wait_idle(cyc);
      n_tests++; if (cyc !== DIVN) begin n_fail++; $display("FAIL div%0d_busy_cycles: got %0d want %0d", i, cyc, DIVN); end
      n_tests++; if (mdif.HI !== ehi[i] || mdif.HI !== m_hi) begin n_fail++; $display("FAIL div%0d_hi: got %h want %h", i, mdif.HI, ehi[i]); end
      n_tests++; if (mdif.LO !== elo[i] || mdif.LO !== m_lo) begin n_fail++; $display("FAIL div%0d_lo: got %h want %h", i, mdif.LO, elo[i]); end
    end
  endtask

  task automatic test_background();
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    model(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      mdif.EX_MD_Op = md_op_t'(9 + i);   // non-HI/LO codes
      #1;
      n_tests++; if (mdif.MD_Stall !== 1'b0 || mdif.MD_Busy !== 1'b1) begin n_fail++; $display("FAIL bg_flow%0d: stall %b busy %b want 0/1", i, mdif.MD_Stall, mdif.MD_Busy); end
      n_tests++; if (mdif.MD_Result !== 32'd0) begin n_fail++; $display("FAIL bg_result%0d: got %h want 0", i, mdif.MD_Result); end
      step();
    end
    n_tests++; if (mdif.LO === 32'd1) begin n_fail++; $display("FAIL bg_early_lo: got %h before completion", mdif.LO); end
    mdif.EX_MD_Op = MD_NOP;
    step();
    n_tests++; if (mdif.MD_Busy !== 1'b0) begin n_fail++; $display("FAIL bg_busy_end: got %b want 0", mdif.MD_Busy); end
    n_tests++; if (mdif.HI !== 32'hFFFF_FFFE || mdif.HI !== m_hi) begin n_fail++; $display("FAIL bg_hi: got %h want fffffffe", mdif.HI); end
    n_tests++; if (mdif.LO !== 32'd1 || mdif.LO !== m_lo) begin n_fail++; $display("FAIL bg_lo: got %h want 1", mdif.LO); end
  endtask

  task automatic test_back_to_back();
    int cnt, cyc;
    logic [31:0] ma, mb;
    mdif.EX_MD_Op = MD_DIV; mdif.EX_Operand_A = 32'd1000; mdif.EX_Operand_B = 32'hFFFF_FFFD;
    mdif.EX_Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (mdif.MD_Busy !== 1'b0) begin n_fail++; $display("FAIL hold_no_accept%0d: busy %b want 0", i, mdif.MD_Busy); end
    end
    mdif.EX_Hold = 1'b0;
    step();
    model(MD_DIV, 32'd1000, 32'hFFFF_FFFD);
    n_tests++; if (mdif.MD_Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_div_accept: busy %b want 1", mdif.MD_Busy); end
    ma = $urandom; mb = $urandom;
    mdif.EX_MD_Op = MD_MULT; mdif.EX_Operand_A = ma; mdif.EX_Operand_B = mb;
    #1;
    cnt = 0;
    while (mdif.MD_Stall && cnt < 200) begin cnt++; step(); end
    n_tests++; if (cnt !== DIVN) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want %0d", cnt, DIVN); end
    n_tests++; if (mdif.HI !== m_hi || mdif.LO !== m_lo) begin n_fail++; $display("FAIL b2b_div_res: got %h/%h want %h/%h", mdif.HI, mdif.LO, m_hi, m_lo); end
    step();
    mdif.EX_MD_Op = MD_NOP;
    model(MD_MULT, ma, mb);
    wait_idle(cyc);
    n_tests++; if (cyc !== MULN) begin n_fail++; $display("FAIL b2b_mul_cycles: got %0d want %0d", cyc, MULN); end
    n_tests++; if (mdif.HI !== m_hi || mdif.LO !== m_lo) begin n_fail++; $display("FAIL b2b_mul_res: got %h/%h want %h/%h", mdif.HI, mdif.LO, m_hi, m_lo); end
  endtask

  task automatic test_reset_mid_div();
    issue(MD_DIVU, 32'hDEAD_BEEF, 32'd17);
    repeat (9) step();
    reset = 1'b1;
    mdif.EX_MD_Op = MD_MFLO;
    step();
    m_hi = 0; m_lo = 0;
    n_tests++; if (mdif.HI !== 32'd0 || mdif.LO !== 32'd0) begin n_fail++; $display("FAIL midreset_hilo: got %h/%h want 0/0", mdif.HI, mdif.LO); end
    n_tests++; if (mdif.MD_Busy !== 1'b0 || mdif.MD_Stall !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: busy %b stall %b want 0/0", mdif.MD_Busy, mdif.MD_Stall); end
    reset = 1'b0;
    mdif.EX_MD_Op = MD_NOP;
    step();
    issue(MD_MTHI, 32'h55, 32'h0);
    model(MD_MTHI, 32'h55, 32'h0);
    n_tests++; if (mdif.HI !== 32'h55 || mdif.MD_Busy !== 1'b0) begin n_fail++; $display("FAIL mthi: hi %h busy %b want 55/0", mdif.HI, mdif.MD_Busy); end
    n_tests++; if (mdif.LO !== m_lo) begin n_fail++; $display("FAIL mthi_lo_kept: got %h want %h", mdif.LO, m_lo); end
  endtask

  task automatic test_random();
    md_op_t      pool [6] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
    md_op_t      op;
    logic [31:0] a, b;
    int          cyc, exp_cyc, hold;
    for (int i = 0; i < 30; i++) begin
      op = pool[$urandom_range(5)];
      a  = $urandom;
      b  = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(3) == 0) a = 32'h8000_0000;
      hold = $urandom_range(2);
      if (hold != 0) begin
        mdif.EX_MD_Op = op; mdif.EX_Operand_A = a; mdif.EX_Operand_B = b;
        mdif.EX_Hold = 1'b1;
        repeat (hold) step();
        n_tests++; if (mdif.MD_Busy !== 1'b0 || mdif.HI !== m_hi || mdif.LO !== m_lo) begin n_fail++; $display("FAIL rnd%0d_held: busy %b hi %h lo %h", i, mdif.MD_Busy, mdif.HI, mdif.LO); end
      end
      issue(op, a, b);
      model(op, a, b);
      exp_cyc = (op == MD_MULT || op == MD_MULTU) ? MULN :
                (op == MD_DIV  || op == MD_DIVU)  ? DIVN : 0;
      wait_idle(cyc);
      n_tests++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL rnd%0d_cycles op %0d: got %0d want %0d", i, op, cyc, exp_cyc); end
      n_tests++; if (mdif.HI !== m_hi || mdif.LO !== m_lo) begin n_fail++; $display("FAIL rnd%0d_hilo op %0d a %h b %h: got %h/%h want %h/%h", i, op, a, b, mdif.HI, mdif.LO, m_hi, m_lo); end
      mdif.EX_MD_Op = MD_MFHI; #1;
      n_tests++; if (mdif.MD_Result !== m_hi) begin n_fail++; $display("FAIL rnd%0d_mfhi: got %h want %h", i, mdif.MD_Result, m_hi); end
      mdif.EX_MD_Op = MD_MFLO; #1;
      n_tests++; if (mdif.MD_Result !== m_lo) begin n_fail++; $display("FAIL rnd%0d_mflo: got %h want %h", i, mdif.MD_Result, m_lo); end
      mdif.EX_MD_Op = MD_NOP;
      step();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    mdif.EX_MD_Op     = MD_NOP;
    mdif.EX_Hold      = 1'b0;
    mdif.EX_Operand_A = '0;
    mdif.EX_Operand_B = '0;
    test_reset();
    test_mult_stall();
    test_div_cases();
    test_background();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
